// File: rtl/warp_fetcher.sv
// warp_fetcher: per-warp PC/mask store with round-robin fetch issue.
// Define FETCHER_PERF_COUNTERS_EN to build the fetch/stall counters.

module warp_fetcher #(
   parameter int unsigned PcWidth   = 32,
   parameter int unsigned NumWarps  = 8,
   parameter int unsigned WarpWidth = 32,
   parameter int unsigned WidWidth  = (NumWarps > 1) ? $clog2(NumWarps) : 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 launch_valid_i,
   output logic                 launch_ready_o,
   input  logic [PcWidth-1:0]   launch_pc_i,
   input  logic [WarpWidth-1:0] launch_act_mask_i,
   output logic [WidWidth-1:0]  launch_warp_id_o,
   input  logic                 ic_ready_i,
   output logic                 fe_valid_o,
   output logic [PcWidth-1:0]   fe_pc_o,
   output logic [WarpWidth-1:0] fe_act_mask_o,
   output logic [WidWidth-1:0]  fe_warp_id_o,
   input  logic                 upd_valid_i,
   input  logic [WidWidth-1:0]  upd_warp_id_i,
   input  logic [PcWidth-1:0]   upd_pc_i,
   input  logic [WarpWidth-1:0] upd_act_mask_i,
   input  logic                 upd_stop_i,
   output logic                 idle_o,
   output logic [31:0]          perf_fetched_o,
   output logic [31:0]          perf_stall_o
);

   typedef enum logic [1:0] {
      W_FREE,
      W_READY,
      W_ISSUED,
      W_WAITING
   } wstate_e;

   wstate_e              state_q [NumWarps];
   wstate_e              state_d [NumWarps];
   logic [PcWidth-1:0]   pc_q    [NumWarps];
   logic [PcWidth-1:0]   pc_d    [NumWarps];
   logic [WarpWidth-1:0] mask_q  [NumWarps];
   logic [WarpWidth-1:0] mask_d  [NumWarps];

   logic                 fe_valid_q, fe_valid_d;
   logic [PcWidth-1:0]   fe_pc_q, fe_pc_d;
   logic [WarpWidth-1:0] fe_mask_q, fe_mask_d;
   logic [WidWidth-1:0]  fe_wid_q, fe_wid_d;
   logic [WidWidth-1:0]  rr_ptr_q, rr_ptr_d;

   logic [NumWarps-1:0]  free_v;
   logic [NumWarps-1:0]  ready_v;
   logic [WidWidth-1:0]  free_id;
   logic                 launch_fire;
   logic                 fe_hs;
   logic                 fe_load;
   logic                 pick_vld;
   logic [WidWidth-1:0]  pick_id;
   int unsigned          arb_idx;
   logic                 upd_hit;
   logic                 upd_live;

   always_comb begin
      free_v  = '0;
      ready_v = '0;
      for (int i = 0; i < int'(NumWarps); i++) begin
         free_v[i]  = (state_q[i] == W_FREE);
         ready_v[i] = (state_q[i] == W_READY);
      end
   end

   // Scan downward so the lowest free slot is the last one written.
   always_comb begin
      free_id = '0;
      for (int i = int'(NumWarps) - 1; i >= 0; i--) begin
         if (free_v[i]) free_id = WidWidth'(i);
      end
   end

   assign launch_ready_o   = |free_v;
   assign launch_warp_id_o = free_id;
   assign launch_fire      = launch_valid_i && launch_ready_o;

   assign fe_hs   = fe_valid_q && ic_ready_i;
   assign fe_load = !fe_valid_q || ic_ready_i;

   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      arb_idx  = 0;
      for (int unsigned k = 1; k <= NumWarps; k++) begin
         arb_idx = 32'(rr_ptr_q) + k;
         if (arb_idx >= NumWarps) arb_idx = arb_idx - NumWarps;
         if (!pick_vld && ready_v[arb_idx[WidWidth-1:0]]) begin
            pick_vld = 1'b1;
            pick_id  = arb_idx[WidWidth-1:0];
         end
      end
   end

   assign upd_hit  = (state_q[upd_warp_id_i] == W_ISSUED) ||
                     (state_q[upd_warp_id_i] == W_WAITING);
   assign upd_live = upd_valid_i && upd_hit;

   // An update landing on an ISSUED warp wins over the handshake move.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      mask_d  = mask_q;
      if (launch_fire) begin
         state_d[free_id] = W_READY;
         pc_d[free_id]    = launch_pc_i;
         mask_d[free_id]  = launch_act_mask_i;
      end
      if (fe_load && pick_vld) state_d[pick_id] = W_ISSUED;
      if (fe_hs && state_q[fe_wid_q] == W_ISSUED) begin
         state_d[fe_wid_q] = W_WAITING;
      end
      if (upd_live) begin
         state_d[upd_warp_id_i] = upd_stop_i ? W_FREE : W_READY;
         pc_d[upd_warp_id_i]    = upd_pc_i;
         mask_d[upd_warp_id_i]  = upd_act_mask_i;
      end
   end

   always_comb begin
      fe_valid_d = fe_valid_q;
      fe_pc_d    = fe_pc_q;
      fe_mask_d  = fe_mask_q;
      fe_wid_d   = fe_wid_q;
      rr_ptr_d   = rr_ptr_q;
      if (fe_load) begin
         fe_valid_d = pick_vld;
         if (pick_vld) begin
            fe_pc_d   = pc_q[pick_id];
            fe_mask_d = mask_q[pick_id];
            fe_wid_d  = pick_id;
            rr_ptr_d  = pick_id;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NumWarps); i++) begin
            state_q[i] <= W_FREE;
            pc_q[i]    <= '0;
            mask_q[i]  <= '0;
         end
         fe_valid_q <= 1'b0;
         fe_pc_q    <= '0;
         fe_mask_q  <= '0;
         fe_wid_q   <= '0;
         rr_ptr_q   <= WidWidth'(NumWarps - 1);
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         mask_q     <= mask_d;
         fe_valid_q <= fe_valid_d;
         fe_pc_q    <= fe_pc_d;
         fe_mask_q  <= fe_mask_d;
         fe_wid_q   <= fe_wid_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   assign fe_valid_o    = fe_valid_q;
   assign fe_pc_o       = fe_pc_q;
   assign fe_act_mask_o = fe_mask_q;
   assign fe_warp_id_o  = fe_wid_q;
   assign idle_o        = (&free_v) && !fe_valid_q;

`ifdef FETCHER_PERF_COUNTERS_EN
   logic [31:0] fetched_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetched_q <= '0;
         stall_q   <= '0;
      end else begin
         if (fe_hs) fetched_q <= fetched_q + 32'd1;
         if (fe_valid_q && !ic_ready_i) stall_q <= stall_q + 32'd1;
      end
   end

   assign perf_fetched_o = fetched_q;
   assign perf_stall_o   = stall_q;
`else
   assign perf_fetched_o = '0;
   assign perf_stall_o   = '0;
`endif

   upd_target_live: assert property (
      @(posedge clk_i) disable iff (!rst_ni) upd_valid_i |-> upd_hit
   );

endmodule

// File: tb/tb_warp_fetcher.sv
// tb_warp_fetcher: directed scenarios plus randomized run against a
// warp-level reference model.

module tb_warp_fetcher;

   localparam int NW = 8;
   localparam int S_FREE = 0;
   localparam int S_RDY  = 1;
   localparam int S_ISS  = 2;
   localparam int S_WAIT = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        launch_valid;
   logic        launch_ready;
   logic [31:0] launch_pc;
   logic [31:0] launch_mask;
   logic [2:0]  launch_wid;
   logic        ic_ready;
   logic        fe_valid;
   logic [31:0] fe_pc;
   logic [31:0] fe_mask;
   logic [2:0]  fe_wid;
   logic        upd_valid;
   logic [2:0]  upd_wid;
   logic [31:0] upd_pc;
   logic [31:0] upd_mask;
   logic        upd_stop;
   logic        idle;
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;

   int total = 0;
   int bad   = 0;

   int          m_st   [NW];
   logic [31:0] m_pc   [NW];
   logic [31:0] m_mask [NW];
   int          m_rr;
   bit          m_fv;
   logic [31:0] m_fpc;
   logic [31:0] m_fmask;
   int          m_fwid;
   logic [31:0] m_fetched;
   logic [31:0] m_stall;

   warp_fetcher dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .launch_valid_i    (launch_valid),
      .launch_ready_o    (launch_ready),
      .launch_pc_i       (launch_pc),
      .launch_act_mask_i (launch_mask),
      .launch_warp_id_o  (launch_wid),
      .ic_ready_i        (ic_ready),
      .fe_valid_o        (fe_valid),
      .fe_pc_o           (fe_pc),
      .fe_act_mask_o     (fe_mask),
      .fe_warp_id_o      (fe_wid),
      .upd_valid_i       (upd_valid),
      .upd_warp_id_i     (upd_wid),
      .upd_pc_i          (upd_pc),
      .upd_act_mask_i    (upd_mask),
      .upd_stop_i        (upd_stop),
      .idle_o            (idle),
      .perf_fetched_o    (perf_fetched),
      .perf_stall_o      (perf_stall)
   );

   always #5 clk = ~clk;

   function automatic int m_lowest_free();
      for (int i = 0; i < NW; i++) if (m_st[i] == S_FREE) return i;
      return -1;
   endfunction

   function automatic bit m_all_free();
      for (int i = 0; i < NW; i++) if (m_st[i] != S_FREE) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NW; i++) begin
         m_st[i] = S_FREE;
         m_pc[i] = '0;
         m_mask[i] = '0;
      end
      m_rr = NW - 1;
      m_fv = 1'b0;
      m_fpc = '0;
      m_fmask = '0;
      m_fwid = 0;
      m_fetched = '0;
      m_stall = '0;
   endfunction

   // One clock of warp-level behaviour, from the inputs now applied.
   function automatic void model_step();
      int          nst   [NW];
      logic [31:0] npc   [NW];
      logic [31:0] nmask [NW];
      int lid;
      int w;
      bit hs;
      bit ld;
      bit found;
      nst = m_st;
      npc = m_pc;
      nmask = m_mask;
      lid = m_lowest_free();
      hs = m_fv && ic_ready;
      ld = !m_fv || ic_ready;
      if (launch_valid && lid >= 0) begin
         nst[lid] = S_RDY;
         npc[lid] = launch_pc;
         nmask[lid] = launch_mask;
      end
      if (hs && m_st[m_fwid] == S_ISS) nst[m_fwid] = S_WAIT;
      if (upd_valid && (m_st[upd_wid] == S_ISS || m_st[upd_wid] == S_WAIT)) begin
         nst[upd_wid] = upd_stop ? S_FREE : S_RDY;
         npc[upd_wid] = upd_pc;
         nmask[upd_wid] = upd_mask;
      end
      if (hs) m_fetched = m_fetched + 1;
      if (m_fv && !ic_ready) m_stall = m_stall + 1;
      if (ld) begin
         found = 1'b0;
         for (int k = 1; k <= NW; k++) begin
            w = (m_rr + k) % NW;
            if (!found && m_st[w] == S_RDY) begin
               found = 1'b1;
               nst[w] = S_ISS;
               m_fpc = m_pc[w];
               m_fmask = m_mask[w];
               m_fwid = w;
               m_rr = w;
            end
         end
         m_fv = found;
      end
      m_st = nst;
      m_pc = npc;
      m_mask = nmask;
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      launch_valid = 1'b0;
      launch_pc = '0;
      launch_mask = '0;
      ic_ready = 1'b0;
      upd_valid = 1'b0;
      upd_wid = '0;
      upd_pc = '0;
      upd_mask = '0;
      upd_stop = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      #3;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (fe_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_fe_valid got=%0b exp=0", fe_valid);
      end
      total++;
      if ({fe_pc, fe_mask, fe_wid} !== 67'd0) begin
         bad++;
         $display("FAIL reset_fe_payload got=%h/%h/%0d exp=0", fe_pc, fe_mask, fe_wid);
      end
      total++;
      if (launch_ready !== 1'b1 || launch_wid !== 3'd0) begin
         bad++;
         $display("FAIL reset_launch got=%0b/%0d exp=1/0", launch_ready, launch_wid);
      end
      total++;
      if (idle !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle got=%0b exp=1", idle);
      end
      total++;
      if (perf_fetched !== 32'd0 || perf_stall !== 32'd0) begin
         bad++;
         $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_fetched, perf_stall);
      end
      launch_valid = 1'b1;
      launch_pc = 32'h0000_0700;
      launch_mask = 32'h0000_00FF;
      cycle();
      launch_valid = 1'b0;
      cycle();
      total++;
      if (fe_valid !== 1'b1) begin
         bad++;
         $display("FAIL midop_pre_valid got=%0b exp=1", fe_valid);
      end
      rst_n = 1'b0;
      #2;
      total++;
      if (fe_valid !== 1'b0 || idle !== 1'b1 || launch_ready !== 1'b1) begin
         bad++;
         $display("FAIL midop_async_clear got=v%0b i%0b r%0b exp=v0 i1 r1",
                  fe_valid, idle, launch_ready);
      end
      do_reset();
   endtask

   task automatic test_first_launch();
      do_reset();
      ic_ready = 1'b1;
      launch_valid = 1'b1;
      launch_pc = 32'h0000_0100;
      launch_mask = 32'hFFFF_FFFF;
      total++;
      if (launch_wid !== 3'd0 || launch_ready !== 1'b1) begin
         bad++;
         $display("FAIL first_launch_id got=%0d/%0b exp=0/1", launch_wid, launch_ready);
      end
      cycle();
      launch_valid = 1'b0;
      total++;
      if (fe_valid !== 1'b0) begin
         bad++;
         $display("FAIL first_launch_early got=%0b exp=0", fe_valid);
      end
      cycle();
      total++;
      if (fe_valid !== 1'b1 || fe_pc !== 32'h100 || fe_wid !== 3'd0 ||
          fe_mask !== 32'hFFFF_FFFF) begin
         bad++;
         $display("FAIL first_launch_req got=v%0b pc=%h wid=%0d m=%h exp=v1 pc=100 wid=0 m=ffffffff",
                  fe_valid, fe_pc, fe_wid, fe_mask);
      end
      total++;
      if (idle !== 1'b0) begin
         bad++;
         $display("FAIL first_launch_idle got=%0b exp=0", idle);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         launch_valid = 1'b1;
         launch_pc = 32'h1000 + 32'(i * 16);
         launch_mask = 32'h1 << i;
         total++;
         if (launch_wid !== 3'(i)) begin
            bad++;
            $display("FAIL b2b_launch_id got=%0d exp=%0d", launch_wid, i);
         end
         cycle();
      end
      launch_valid = 1'b0;
      cycle();
      ic_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (fe_valid !== 1'b1 || fe_wid !== 3'(i) || fe_pc !== 32'h1000 + 32'(i * 16)) begin
            bad++;
            $display("FAIL b2b_order got=v%0b wid=%0d pc=%h exp=v1 wid=%0d pc=%h",
                     fe_valid, fe_wid, fe_pc, i, 32'h1000 + 32'(i * 16));
         end
         cycle();
      end
      for (int i = 0; i < 2; i++) begin
         total++;
         if (fe_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_no_repeat got=v%0b wid=%0d exp=v0", fe_valid, fe_wid);
         end
         cycle();
      end
   endtask

   task automatic test_stall();
      logic [31:0] exp_stall;
      logic [31:0] exp_fetch;
`ifdef FETCHER_PERF_COUNTERS_EN
      exp_stall = 32'd5;
      exp_fetch = 32'd1;
`else
      exp_stall = 32'd0;
      exp_fetch = 32'd0;
`endif
      do_reset();
      launch_valid = 1'b1;
      launch_pc = 32'h0000_2000;
      launch_mask = 32'hA5A5_A5A5;
      cycle();
      launch_valid = 1'b0;
      cycle();
      for (int i = 0; i < 5; i++) begin
         cycle();
         total++;
         if (fe_valid !== 1'b1 || fe_pc !== 32'h2000 || fe_mask !== 32'hA5A5_A5A5 ||
             fe_wid !== 3'd0) begin
            bad++;
            $display("FAIL stall_stable cyc=%0d got=v%0b pc=%h m=%h wid=%0d", i,
                     fe_valid, fe_pc, fe_mask, fe_wid);
         end
      end
      total++;
      if (perf_stall !== exp_stall) begin
         bad++;
         $display("FAIL stall_count got=%0d exp=%0d", perf_stall, exp_stall);
      end
      ic_ready = 1'b1;
      cycle();
      total++;
      if (perf_fetched !== exp_fetch || perf_stall !== exp_stall || fe_valid !== 1'b0) begin
         bad++;
         $display("FAIL stall_release got=f%0d s%0d v%0b exp=f%0d s%0d v0",
                  perf_fetched, perf_stall, fe_valid, exp_fetch, exp_stall);
      end
   endtask

   task automatic test_update();
      do_reset();
      ic_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         launch_valid = 1'b1;
         launch_pc = 32'h100 * 32'(i + 1);
         launch_mask = 32'hFFFF_FFFF;
         cycle();
      end
      launch_valid = 1'b0;
      repeat (6) cycle();
      total++;
      if (fe_valid !== 1'b0) begin
         bad++;
         $display("FAIL upd_drained got=%0b exp=0", fe_valid);
      end
      upd_valid = 1'b1;
      upd_wid = 3'd2;
      upd_pc = 32'h0000_0204;
      upd_mask = 32'h0000_FFFF;
      upd_stop = 1'b0;
      cycle();
      upd_valid = 1'b0;
      total++;
      if (fe_valid !== 1'b0) begin
         bad++;
         $display("FAIL upd_latency got=%0b exp=0", fe_valid);
      end
      cycle();
      total++;
      if (fe_valid !== 1'b1 || fe_wid !== 3'd2 || fe_pc !== 32'h204 ||
          fe_mask !== 32'h0000_FFFF) begin
         bad++;
         $display("FAIL upd_values got=v%0b wid=%0d pc=%h m=%h exp=v1 wid=2 pc=204 m=0000ffff",
                  fe_valid, fe_wid, fe_pc, fe_mask);
      end
      ic_ready = 1'b0;
      upd_valid = 1'b1;
      upd_wid = 3'd0;
      upd_pc = 32'h300;
      upd_mask = 32'h1;
      cycle();
      upd_wid = 3'd3;
      upd_pc = 32'h330;
      upd_mask = 32'h8;
      cycle();
      upd_valid = 1'b0;
      total++;
      if (fe_wid !== 3'd2 || fe_pc !== 32'h204) begin
         bad++;
         $display("FAIL upd_hold got=wid%0d pc=%h exp=wid2 pc=204", fe_wid, fe_pc);
      end
      ic_ready = 1'b1;
      cycle();
      total++;
      if (fe_valid !== 1'b1 || fe_wid !== 3'd3 || fe_pc !== 32'h330) begin
         bad++;
         $display("FAIL rr_first got=v%0b wid=%0d pc=%h exp=v1 wid=3 pc=330",
                  fe_valid, fe_wid, fe_pc);
      end
      cycle();
      total++;
      if (fe_valid !== 1'b1 || fe_wid !== 3'd0 || fe_pc !== 32'h300) begin
         bad++;
         $display("FAIL rr_wrap got=v%0b wid=%0d pc=%h exp=v1 wid=0 pc=300",
                  fe_valid, fe_wid, fe_pc);
      end
      cycle();
   endtask

   task automatic test_full_stop();
      do_reset();
      for (int i = 0; i < NW; i++) begin
         launch_valid = 1'b1;
         launch_pc = 32'h3000 + 32'(i * 4);
         launch_mask = 32'hF0F0_0000 | 32'(i);
         cycle();
      end
      launch_valid = 1'b0;
      total++;
      if (launch_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ready got=%0b exp=0", launch_ready);
      end
      ic_ready = 1'b1;
      repeat (10) cycle();
      upd_valid = 1'b1;
      upd_wid = 3'd5;
      upd_stop = 1'b1;
      total++;
      if (launch_ready !== 1'b0) begin
         bad++;
         $display("FAIL stop_same_cycle got=%0b exp=0", launch_ready);
      end
      cycle();
      upd_valid = 1'b0;
      upd_stop = 1'b0;
      total++;
      if (launch_ready !== 1'b1 || launch_wid !== 3'd5) begin
         bad++;
         $display("FAIL stop_free got=%0b/%0d exp=1/5", launch_ready, launch_wid);
      end
      launch_valid = 1'b1;
      launch_pc = 32'h5550;
      launch_mask = 32'h55;
      cycle();
      launch_valid = 1'b0;
      total++;
      if (launch_ready !== 1'b0 || fe_valid !== 1'b0) begin
         bad++;
         $display("FAIL relaunch_full got=r%0b v%0b exp=r0 v0", launch_ready, fe_valid);
      end
      cycle();
      total++;
      if (fe_valid !== 1'b1 || fe_wid !== 3'd5 || fe_pc !== 32'h5550) begin
         bad++;
         $display("FAIL relaunch_req got=v%0b wid=%0d pc=%h exp=v1 wid=5 pc=5550",
                  fe_valid, fe_wid, fe_pc);
      end
   endtask

   task automatic test_race();
      do_reset();
      launch_valid = 1'b1;
      launch_pc = 32'h40;
      launch_mask = 32'hF;
      cycle();
      launch_valid = 1'b0;
      cycle();
      total++;
      if (fe_valid !== 1'b1 || fe_wid !== 3'd0) begin
         bad++;
         $display("FAIL race_setup got=v%0b wid=%0d exp=v1 wid=0", fe_valid, fe_wid);
      end
      ic_ready = 1'b1;
      upd_valid = 1'b1;
      upd_wid = 3'd0;
      upd_pc = 32'h80;
      upd_mask = 32'hF0;
      upd_stop = 1'b0;
      cycle();
      upd_valid = 1'b0;
      total++;
      if (fe_valid !== 1'b0) begin
         bad++;
         $display("FAIL race_gap got=%0b exp=0", fe_valid);
      end
      cycle();
      total++;
      if (fe_valid !== 1'b1 || fe_wid !== 3'd0 || fe_pc !== 32'h80 || fe_mask !== 32'hF0) begin
         bad++;
         $display("FAIL race_new_pc got=v%0b wid=%0d pc=%h m=%h exp=v1 wid=0 pc=80 m=f0",
                  fe_valid, fe_wid, fe_pc, fe_mask);
      end
   endtask

   task automatic test_random();
      int cand [$];
      int lf;
      logic [31:0] ef;
      logic [31:0] es;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         launch_valid = ($urandom % 3) == 0;
         launch_pc = $urandom;
         launch_mask = $urandom;
         ic_ready = ($urandom % 4) != 0;
         cand.delete();
         for (int w = 0; w < NW; w++) begin
            if (m_st[w] == S_WAIT) cand.push_back(w);
            if (m_st[w] == S_ISS && m_fv && m_fwid == w && ic_ready) cand.push_back(w);
         end
         upd_valid = 1'b0;
         upd_stop = 1'b0;
         if (cand.size() > 0 && ($urandom % 2) == 0) begin
            upd_valid = 1'b1;
            upd_wid = 3'(cand[$urandom_range(cand.size() - 1, 0)]);
            upd_pc = $urandom;
            upd_mask = $urandom;
            upd_stop = ($urandom % 4) == 0;
         end
         cycle();
         total++;
         if (fe_valid !== m_fv) begin
            bad++;
            $display("FAIL rnd_valid n=%0d got=%0b exp=%0b", n, fe_valid, m_fv);
         end
         if (m_fv) begin
            total++;
            if (fe_pc !== m_fpc || fe_mask !== m_fmask || fe_wid !== 3'(m_fwid)) begin
               bad++;
               $display("FAIL rnd_req n=%0d got=%h/%h/%0d exp=%h/%h/%0d", n,
                        fe_pc, fe_mask, fe_wid, m_fpc, m_fmask, m_fwid);
            end
         end
         lf = m_lowest_free();
         total++;
         if (launch_ready !== (lf >= 0) || (lf >= 0 && launch_wid !== 3'(lf))) begin
            bad++;
            $display("FAIL rnd_launch n=%0d got=%0b/%0d exp_free=%0d", n,
                     launch_ready, launch_wid, lf);
         end
         total++;
         if (idle !== (m_all_free() && !m_fv)) begin
            bad++;
            $display("FAIL rnd_idle n=%0d got=%0b", n, idle);
         end
`ifdef FETCHER_PERF_COUNTERS_EN
         ef = m_fetched;
         es = m_stall;
`else
         ef = '0;
         es = '0;
`endif
         total++;
         if (perf_fetched !== ef || perf_stall !== es) begin
            bad++;
            $display("FAIL rnd_perf n=%0d got=%0d/%0d exp=%0d/%0d", n,
                     perf_fetched, perf_stall, ef, es);
         end
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      model_reset();
      test_reset();
      test_first_launch();
      test_back_to_back();
      test_stall();
      test_update();
      test_full_stop();
      test_race();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
